// File: rtl/kofn_vote_filter.sv
// Registered k-of-N voter with a persistence (debounce) filter on the voted output and
// saturating per-channel disagreement counters. Masked channels neither vote nor count.
module kofn_vote_filter #(
  parameter int unsigned N       = 3,
  parameter int unsigned THRESH  = 2,
  parameter int unsigned PERSIST = 4,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         din,
  input  logic [N-1:0]         mask,
  input  logic                 clr_err,
  output logic                 vote,
  output logic                 y,
  output logic                 y_valid,
  output logic [N-1:0]         dis,
  output logic [N*ERR_W-1:0]   err_cnt
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PC_W  = $clog2(PERSIST) + 1;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PERSIST - 1);
  localparam logic [PC_W-1:0]  VC_MAX   = PC_W'(PERSIST);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  // Stage 1 state
  logic [N-1:0]       din_q, mask_q;
  logic               vote_q, vote_d;
  logic [N-1:0]       active;
  logic [CNT_W-1:0]   cnt1;

  // Stage 2 state
  logic               y_q, y_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    vc_q, vc_d;

  // Error tracking
  logic [N-1:0]       dis_q, dis_d;
  logic [N*ERR_W-1:0] err_q, err_d;

  assign active = din & ~mask;

  always_comb begin
    cnt1 = '0;
    for (int i = 0; i < N; i++) begin
      cnt1 = cnt1 + CNT_W'(active[i]);
    end
  end

  // A fully masked input set never votes 1, even for degenerate thresholds.
  assign vote_d = (mask != '1) && (cnt1 >= THRESH_C);

  always_comb begin
    y_d  = y_q;
    pc_d = pc_q;
    if (vote_q == y_q) begin
      pc_d = '0;
    end else if (pc_q == PC_LAST) begin
      y_d  = vote_q;
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end
  end

  assign vc_d = (vc_q == VC_MAX) ? vc_q : vc_q + 1'b1;

  // dis is taken from the stage-1 snapshot so it lines up with the vote that snapshot made.
  assign dis_d = ~mask_q & (din_q ^ {N{vote_q}});

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < N; i++) begin
      if (clr_err) begin
        err_d[i*ERR_W +: ERR_W] = '0;
      end else if (en && dis_q[i] && (err_q[i*ERR_W +: ERR_W] != ERR_MAX)) begin
        err_d[i*ERR_W +: ERR_W] = err_q[i*ERR_W +: ERR_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      mask_q <= '0;
      vote_q <= 1'b0;
      y_q    <= 1'b0;
      pc_q   <= '0;
      vc_q   <= '0;
      dis_q  <= '0;
    end else if (en) begin
      din_q  <= din;
      mask_q <= mask;
      vote_q <= vote_d;
      y_q    <= y_d;
      pc_q   <= pc_d;
      vc_q   <= vc_d;
      dis_q  <= dis_d;
    end
  end

  // Separate process: clr_err must act even while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign vote    = vote_q;
  assign y       = y_q;
  assign y_valid = (vc_q == VC_MAX);
  assign dis     = dis_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_kofn_vote_filter.sv
// Self-checking bench for kofn_vote_filter (N=3, THRESH=2, PERSIST=4, ERR_W=4): a cycle model
// feeds an expected-output queue, plus directed constant checks of the key scenarios.
module tb_kofn_vote_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  din;
  logic [2:0]  mask;
  logic        clr_err;
  logic        vote;
  logic        y;
  logic        y_valid;
  logic [2:0]  dis;
  logic [11:0] err_cnt;
  logic [17:0] dut_obs;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] sb[$];
  logic [17:0] exp_obs;
  logic [7:0]  vote_tab = 8'b1110_1000;

  // Reference model state
  logic        m_vote, m_y;
  int          m_pc, m_vc;
  logic [2:0]  m_dinq, m_maskq, m_dis;
  int          m_err[3];

  kofn_vote_filter #(
    .N      (3),
    .THRESH (2),
    .PERSIST(4),
    .ERR_W  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .din    (din),
    .mask   (mask),
    .clr_err(clr_err),
    .vote   (vote),
    .y      (y),
    .y_valid(y_valid),
    .dis    (dis),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign dut_obs = {vote, y, y_valid, dis, err_cnt};

  function automatic logic [17:0] model_obs();
    return {m_vote, m_y, (m_vc >= 4), m_dis, 4'(m_err[2]), 4'(m_err[1]), 4'(m_err[0])};
  endfunction

  task automatic model_reset();
    m_vote = 0; m_y = 0; m_pc = 0; m_vc = 0;
    m_dinq = 0; m_maskq = 0; m_dis = 0;
    for (int i = 0; i < 3; i++) m_err[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] d, input logic [2:0] m, input logic e,
                            input logic c);
    int         cnt;
    logic       nvote, ny;
    int         npc;
    logic [2:0] ndis;
    int         nerr[3];
    if (e) begin
      cnt = 0;
      for (int i = 0; i < 3; i++) if (d[i] && !m[i]) cnt++;
      nvote = (cnt >= 2);
      ny = m_y;
      npc = m_pc;
      if (m_vote == m_y) npc = 0;
      else if (m_pc == 3) begin ny = m_vote; npc = 0; end
      else npc = m_pc + 1;
      for (int i = 0; i < 3; i++) begin
        ndis[i] = !m_maskq[i] && (m_dinq[i] != m_vote);
        nerr[i] = (m_dis[i] && m_err[i] < 15) ? m_err[i] + 1 : m_err[i];
      end
      m_vote = nvote; m_y = ny; m_pc = npc;
      m_dinq = d; m_maskq = m; m_dis = ndis;
      for (int i = 0; i < 3; i++) m_err[i] = nerr[i];
      if (m_vc < 4) m_vc++;
    end
    if (c) for (int i = 0; i < 3; i++) m_err[i] = 0;
  endtask

  // Drive one cycle, push the model's expectation, land 1 time unit after the edge.
  task automatic cycle(input logic [2:0] d, input logic [2:0] m, input logic e, input logic c);
    @(negedge clk);
    din = d; mask = m; en = e; clr_err = c;
    model_step(d, m, e, c);
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en = 0; clr_err = 0;
    rst = 1;
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    din = 3'b111; mask = 0; en = 1; clr_err = 0; rst = 0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1;
    #1;
    n_cmp++;
    if (dut_obs !== 18'h0) begin
      n_bad++; $display("FAIL reset_async got %h want %h", dut_obs, 18'h0);
    end
    model_reset();
    @(negedge clk);
    en = 0;
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle(3'b000, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs) begin
        n_bad++; $display("FAIL reset_model k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
      n_cmp++;
      if (y_valid !== (k >= 4)) begin
        n_bad++; $display("FAIL y_valid_rise k=%0d got %b want %b", k, y_valid, (k >= 4));
      end
    end
  endtask

  task automatic test_truth_table();
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 6; k++) begin
        cycle(3'(v), 3'b000, 1'b1, 1'b0);
        exp_obs = sb.pop_front();
        n_cmp++;
        if (dut_obs !== exp_obs) begin
          n_bad++; $display("FAIL truth_model din=%0d k=%0d got %h want %h", v, k, dut_obs, exp_obs);
        end
      end
      n_cmp++;
      if (vote !== vote_tab[v] || y !== vote_tab[v]) begin
        n_bad++;
        $display("FAIL truth_table din=%0d got vote=%b y=%b want %b", v, vote, y, vote_tab[v]);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 6; k++) begin
      cycle(3'b000, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs) begin
        n_bad++; $display("FAIL glitch_settle k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
    end
    for (int k = 0; k < 9; k++) begin
      cycle((k < 3) ? 3'b111 : 3'b000, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs || y !== 1'b0) begin
        n_bad++; $display("FAIL glitch_reject k=%0d got %h want %h (y=0)", k, dut_obs, exp_obs);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      cycle(3'b111, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs || y !== (k == 5)) begin
        n_bad++;
        $display("FAIL glitch_accept edge=%0d got %h y=%b want %h y=%b", k, dut_obs, y, exp_obs,
                 (k == 5));
      end
    end
  endtask

  task automatic test_fault_count();
    apply_reset();
    for (int k = 1; k <= 25; k++) begin
      cycle(3'b011, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs) begin
        n_bad++; $display("FAIL fault_model edge=%0d got %h want %h", k, dut_obs, exp_obs);
      end
      if (k == 3) begin
        n_cmp++;
        if (err_cnt[11:8] !== 4'd1) begin
          n_bad++; $display("FAIL fault_first got %0d want 1", err_cnt[11:8]);
        end
      end
    end
    n_cmp++;
    if (err_cnt !== 12'hF00 || dis !== 3'b100) begin
      n_bad++; $display("FAIL fault_saturate got err=%h dis=%b want err=f00 dis=100", err_cnt, dis);
    end
  endtask

  task automatic test_clear();
    cycle(3'b011, 3'b000, 1'b1, 1'b1);
    exp_obs = sb.pop_front();
    n_cmp++;
    if (dut_obs !== exp_obs || err_cnt[11:8] !== 4'd0) begin
      n_bad++; $display("FAIL clear_wins got %h want %h", dut_obs, exp_obs);
    end
    cycle(3'b011, 3'b000, 1'b1, 1'b0);
    exp_obs = sb.pop_front();
    n_cmp++;
    if (dut_obs !== exp_obs || err_cnt[11:8] !== 4'd1) begin
      n_bad++; $display("FAIL clear_resume got %h want %h", dut_obs, exp_obs);
    end
    cycle(3'b011, 3'b000, 1'b0, 1'b1);
    exp_obs = sb.pop_front();
    n_cmp++;
    if (dut_obs !== exp_obs || err_cnt !== 12'h000 || dis !== 3'b100) begin
      n_bad++; $display("FAIL clear_no_en got %h want %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_mask();
    for (int k = 0; k < 2; k++) begin
      cycle(3'b101, 3'b100, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs || vote !== 1'b0) begin
        n_bad++; $display("FAIL mask_one k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
    end
    cycle(3'b101, 3'b000, 1'b1, 1'b0);
    exp_obs = sb.pop_front();
    n_cmp++;
    if (dut_obs !== exp_obs || vote !== 1'b1) begin
      n_bad++; $display("FAIL mask_none got %h want %h", dut_obs, exp_obs);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(3'b101, 3'b111, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs) begin
        n_bad++; $display("FAIL mask_all k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
    end
    n_cmp++;
    if (vote !== 1'b0 || dis !== 3'b000) begin
      n_bad++; $display("FAIL mask_all_end got vote=%b dis=%b want 0 000", vote, dis);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      cycle((k < 6) ? 3'b000 : 3'b111, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs) begin
        n_bad++; $display("FAIL en_setup k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(3'b000, 3'b010, 1'b0, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs || vote !== 1'b1 || y !== 1'b0) begin
        n_bad++; $display("FAIL en_freeze k=%0d got %h want %h", k, dut_obs, exp_obs);
      end
    end
    for (int k = 1; k <= 2; k++) begin
      cycle(3'b111, 3'b000, 1'b1, 1'b0);
      exp_obs = sb.pop_front();
      n_cmp++;
      if (dut_obs !== exp_obs || y !== (k == 2)) begin
        n_bad++; $display("FAIL en_resume edge=%0d got %h y=%b want %h", k, dut_obs, y, exp_obs);
      end
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_cmp++;
    if (dut_obs !== 18'h0) begin
      n_bad++; $display("FAIL en_async_rst got %h want %h", dut_obs, 18'h0);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 0; clr_err = 0; din = 0; mask = 0;
    model_reset();
    #12 rst = 0;
    test_reset();
    test_truth_table();
    test_glitch();
    test_fault_count();
    test_clear();
    test_mask();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
